// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table (turn = 2^32), guard bits,
// and rounding of a table entry to the phase width in use.
package cordic_pkg;

   localparam int GUARD = 2;

   // round(atan(2^-i) / 2pi * 2^32)
   function automatic logic [31:0] atan_turn(input int i);
      case (i)
         0:       return 32'h20000000;
         1:       return 32'h12E4051E;
         2:       return 32'h09FB385B;
         3:       return 32'h051111D4;
         4:       return 32'h028B0D43;
         5:       return 32'h0145D7E1;
         6:       return 32'h00A2F61E;
         7:       return 32'h00517C55;
         8:       return 32'h0028BE53;
         9:       return 32'h00145F2F;
         10:      return 32'h000A2F98;
         11:      return 32'h000517CC;
         12:      return 32'h00028BE6;
         13:      return 32'h000145F3;
         14:      return 32'h0000A2FA;
         15:      return 32'h0000517D;
         16:      return 32'h000028BE;
         17:      return 32'h0000145F;
         18:      return 32'h00000A30;
         19:      return 32'h00000518;
         20:      return 32'h0000028C;
         21:      return 32'h00000146;
         22:      return 32'h000000A3;
         23:      return 32'h00000051;
         24:      return 32'h00000029;
         25:      return 32'h00000014;
         26:      return 32'h0000000A;
         27:      return 32'h00000005;
         28:      return 32'h00000003;
         29:      return 32'h00000001;
         30:      return 32'h00000001;
         default: return 32'h00000000;
      endcase
   endfunction

   // Table entry rounded (half up) to zw bits; result right-aligned.
   function automatic logic [31:0] cordic_const(input int i, input int zw);
      logic [32:0] r;
      if (zw >= 32) return atan_turn(i);
      r = ({1'b0, atan_turn(i)} + (33'd1 << (31 - zw))) >> (32 - zw);
      return r[31:0];
   endfunction

endpackage

// File: rtl/cordic_pipe_if.sv
// Sample bus of the CORDIC pipe: input vector/phase/mode and result.
interface cordic_pipe_if #(
   parameter int bitwidth = 16,
   parameter int zwidth   = 16
);
   logic                       in_valid;
   logic                       mode;
   logic signed [bitwidth-1:0] xi;
   logic signed [bitwidth-1:0] yi;
   logic [zwidth-1:0]          zi;
   logic                       out_valid;
   logic                       mode_o;
   logic signed [bitwidth+1:0] xo;
   logic signed [bitwidth+1:0] yo;
   logic [zwidth-1:0]          zo;

   modport master (
      output in_valid, mode, xi, yi, zi,
      input  out_valid, mode_o, xo, yo, zo
   );

   modport slave (
      input  in_valid, mode, xi, yi, zi,
      output out_valid, mode_o, xo, yo, zo
   );
endinterface

// File: rtl/cordic_pipe_iter.sv
// One registered CORDIC micro-rotation. Direction comes from z in rotation
// mode and from the sign of y in vectoring mode; valid/mode ride along.
module cordic_iter #(
   parameter int          W      = 18,
   parameter int          zwidth = 16,
   parameter int          shift  = 0,
   parameter logic [31:0] angle  = 32'h0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic                in_valid,
   input  logic                mode,
   input  logic signed [W-1:0] x,
   input  logic signed [W-1:0] y,
   input  logic [zwidth-1:0]   z,
   output logic                out_valid,
   output logic                mode_o,
   output logic signed [W-1:0] xo,
   output logic signed [W-1:0] yo,
   output logic [zwidth-1:0]   zo
);

   localparam logic [zwidth-1:0] C = angle[zwidth-1:0];

   logic signed [W-1:0] x_sh;
   logic signed [W-1:0] y_sh;
   logic                d_pos;

   assign x_sh  = x >>> shift;
   assign y_sh  = y >>> shift;
   // d = +1: rotation with z >= 0, or vectoring with y < 0
   assign d_pos = mode ? y[W-1] : ~z[zwidth-1];

   // Micro-rotation register; holds entirely while enable is low
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         mode_o    <= 1'b0;
         xo        <= '0;
         yo        <= '0;
         zo        <= '0;
      end else if (enable) begin
         out_valid <= in_valid;
         mode_o    <= mode;
         if (d_pos) begin
            xo <= x - y_sh;
            yo <= y + x_sh;
            zo <= z - C;
         end else begin
            xo <= x + y_sh;
            yo <= y - x_sh;
            zo <= z + C;
         end
      end
   end

endmodule

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC: quadrant pre-rotation register followed by
// 'stages' micro-rotations. Rotation or vectoring selectable per sample.
module cordic_pipe
   import cordic_pkg::*;
#(
   parameter int bitwidth = 16,
   parameter int zwidth   = 16,
   parameter int stages   = 12
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          enable,
   cordic_pipe_if.slave  bus
);

   localparam int W = bitwidth + GUARD;

   logic signed [W-1:0] x_ext;
   logic signed [W-1:0] y_ext;
   logic                flip;

   logic                p_vld;
   logic                p_mode;
   logic signed [W-1:0] p_x;
   logic signed [W-1:0] p_y;
   logic [zwidth-1:0]   p_z;

   logic                vld_pipe  [0:stages];
   logic                mode_pipe [0:stages];
   logic signed [W-1:0] x_pipe    [0:stages];
   logic signed [W-1:0] y_pipe    [0:stages];
   logic [zwidth-1:0]   z_pipe    [0:stages];

   // Guard bits make negation of the most negative input exact
   assign x_ext = {{GUARD{bus.xi[bitwidth-1]}}, bus.xi};
   assign y_ext = {{GUARD{bus.yi[bitwidth-1]}}, bus.yi};

   // Rotate by 180 deg when the angle is outside +/-90 deg (rotation)
   // or the vector lies in the left half-plane (vectoring)
   assign flip = bus.mode ? bus.xi[bitwidth-1]
                          : (bus.zi[zwidth-1] ^ bus.zi[zwidth-2]);

   // Pre-rotation register
   always_ff @(posedge clock) begin
      if (reset) begin
         p_vld  <= 1'b0;
         p_mode <= 1'b0;
         p_x    <= '0;
         p_y    <= '0;
         p_z    <= '0;
      end else if (enable) begin
         p_vld  <= bus.in_valid;
         p_mode <= bus.mode;
         p_x    <= flip ? -x_ext : x_ext;
         p_y    <= flip ? -y_ext : y_ext;
         p_z    <= {bus.zi[zwidth-1] ^ flip, bus.zi[zwidth-2:0]};
      end
   end

   assign vld_pipe[0]  = p_vld;
   assign mode_pipe[0] = p_mode;
   assign x_pipe[0]    = p_x;
   assign y_pipe[0]    = p_y;
   assign z_pipe[0]    = p_z;

   for (genvar i = 0; i < stages; i++) begin : g_stage
      cordic_iter #(
         .W      (W),
         .zwidth (zwidth),
         .shift  (i),
         .angle  (cordic_const(i, zwidth))
      ) u_iter (
         .clock     (clock),
         .reset     (reset),
         .enable    (enable),
         .in_valid  (vld_pipe[i]),
         .mode      (mode_pipe[i]),
         .x         (x_pipe[i]),
         .y         (y_pipe[i]),
         .z         (z_pipe[i]),
         .out_valid (vld_pipe[i+1]),
         .mode_o    (mode_pipe[i+1]),
         .xo        (x_pipe[i+1]),
         .yo        (y_pipe[i+1]),
         .zo        (z_pipe[i+1])
      );
   end

   assign bus.out_valid = vld_pipe[stages];
   assign bus.mode_o    = mode_pipe[stages];
   assign bus.xo        = x_pipe[stages];
   assign bus.yo        = y_pipe[stages];
   assign bus.zo        = z_pipe[stages];

endmodule

// File: doc/cordic_pipe.md
# cordic_pipe

Fully pipelined, parametrised CORDIC engine that chains `stages` micro-rotation iterations behind a quadrant pre-rotation stage. It supports both rotation mode (rotate vector by angle, for NCO/mixer use in the DDC/DUC chains) and vectoring mode (magnitude/phase, for AGC and phase detection), selectable per sample. A valid bit travels with each sample, and a clock enable stalls the whole pipe.

## Interface
- `bitwidth`, 16: input x/y width, two's complement.
- `zwidth`, 16: phase width; full turn = 2^zwidth; range 8..32.
- `stages`, 12: number of micro-rotations; range 1..zwidth-1.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  pipeline clock enable; low = every register holds.
- `in_valid`  in  1  sample qualifier on xi/yi/zi/mode.
- `mode`  in  1  0 = rotation, 1 = vectoring.
- `xi`, `yi`  in  bitwidth  input vector.
- `zi`  in  zwidth  input phase (rotation) or phase offset (vectoring).
- `out_valid`  out  1  output qualifier.
- `mode_o`  out  1  mode that travelled with the sample.
- `xo`, `yo`  out  bitwidth+2  result, CORDIC gain (~1.6468) not compensated.
- `zo`  out  zwidth  residual phase (rotation) or accumulated angle (vectoring).

## Operation
- Internal x/y width W = bitwidth+2. Inputs are sign-extended by 2 guard bits. No saturation: the guard bits cover gain × √2.
- Pre-rotation stage (P):
  - Rotation mode: if zi[zwidth-1] != zi[zwidth-2] (|angle| ≥ 90°), negate x and y and invert zi[zwidth-1] (add 180°).
  - Vectoring mode: if xi < 0, negate x and y and invert zi[zwidth-1].
  - Otherwise pass through.
  - Negating the most negative input is exact, thanks to the guard bits.
- Stage i (i = 0..stages-1): shift = i, constant C_i = round(atan(2^-i)/2π · 2^zwidth).
  - Direction d = +1 if (rotation: z ≥ 0) or (vectoring: y < 0); else d = -1.
  - x' = x − d·(y>>>i), y' = y + d·(x>>>i), z' = z − d·C_i.
  - `>>>` is an arithmetic shift, truncating toward −∞. Phase arithmetic is modulo 2^zwidth.
- `mode` and `in_valid` are pipelined alongside the data. An invalid sample still propagates data, but `out_valid` is 0.
- Convergence range after P is ±90° within the ±99.7° CORDIC range. Vectoring drives y toward 0; rotation drives z toward 0.

## Timing
- Latency: exactly stages+1 enabled clocks from an in_valid sample to its out_valid (P register + one register per stage). Throughput is one sample per enabled clock.
- enable low: no register changes, including the valid/mode pipes. A sample presented while enable is low is not captured.
- Reset (any cycle, including mid-stream): every data, mode and valid register clears to 0 on the next edge. xo=yo=zo=0, mode_o=0, out_valid=0. In-flight samples are discarded.
- Reset has priority over enable.
- Back-to-back valid samples with alternating mode must each use their own mode at every stage.

## Structure
- Shared package `cordic_pkg`:
  - 32-entry table of 32-bit atan constants (turn = 2^32).
  - Function `cordic_const(i, zwidth)` returning the table entry rounded to zwidth bits.
  - Guard-bit constant (2).
- Sub-module `cordic_iter`: one registered micro-rotation. It takes the shift and constant as parameters, the mode bit as a port, and W/zwidth widths. It carries valid/mode through with the same enable and reset.
- Top: the P stage plus a generate loop of `cordic_iter`.

## Test plan
Defaults: bitwidth=16, zwidth=16, stages=12; tolerances ±4 LSB on x/y, ±3 LSB on z.
- Rotation, xi=10000, yi=0, zi=16384 (90°) → after 13 enabled cycles: xo≈0, yo≈16468, zo≈0, out_valid=1.
- Vectoring, xi=3000, yi=4000, zi=0 → xo≈8234, yo≈0, zo≈9672 (53.13°).
- Pre-rotation:
  - Rotation xi=10000, yi=0, zi=0x8000 → xo≈−16468, yo≈0.
  - Vectoring xi=−10000, yi=0, zi=0 → xo≈16468, zo≈0x8000.
- Extremes: xi=yi=−32768 in vectoring mode → no wrap; xo≈76317 fits W=18, zo≈−24576 (−135°).
- Control:
  - Toggle enable randomly over a stream of 50 alternating-mode samples → outputs match a golden model in order, with exactly stages+1 enabled-cycle latency.
  - Assert reset mid-stream → out_valid=0 and all outputs 0 on the next edge; no stale sample emerges after reset releases.
